// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin between ALU and LSB result ports, each
// buffered by a small FIFO, with same-cycle bypass when the winner's FIFO is empty.
module cdb_arbiter #(
  parameter int unsigned ENTRY_W = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               alu_valid,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [31:0]        alu_value,
  input  logic [31:0]        alu_pc,
  output logic               alu_full,
  input  logic               lsb_valid,
  input  logic [ENTRY_W-1:0] lsb_entry,
  input  logic [31:0]        lsb_value,
  output logic               lsb_full,
  output logic               cdb_valid,
  output logic               cdb_src,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [31:0]        cdb_value,
  output logic [31:0]        cdb_pc,
  output logic               overflow_err
);

  localparam int unsigned AW = ENTRY_W + 64;
  localparam int unsigned LW = ENTRY_W + 32;
  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  logic [AW-1:0]      a_mem_q [DEPTH];
  logic [AW-1:0]      a_mem_d [DEPTH];
  logic [LW-1:0]      l_mem_q [DEPTH];
  logic [LW-1:0]      l_mem_d [DEPTH];
  logic [PTR_W-1:0]   a_wp_q, a_wp_d, a_rp_q, a_rp_d;
  logic [PTR_W-1:0]   l_wp_q, l_wp_d, l_rp_q, l_rp_d;
  logic [PTR_W:0]     a_cnt_q, a_cnt_d, l_cnt_q, l_cnt_d;
  logic               last_q, last_d;  // 1 = LSB granted last
  logic               valid_q, valid_d, src_q, src_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [31:0]        value_q, value_d, pc_q, pc_d;
  logic               ovf_q, ovf_d;

  logic          a_empty, l_empty, a_cand, l_cand, gnt_a, gnt_l;
  logic          push_a, push_l, pop_a, pop_l, ok_push_a, ok_push_l;
  logic [AW-1:0] a_item;
  logic [LW-1:0] l_item;

  assign alu_full     = (a_cnt_q == FullCnt);
  assign lsb_full     = (l_cnt_q == FullCnt);
  assign cdb_valid    = valid_q;
  assign cdb_src      = src_q;
  assign cdb_entry    = entry_q;
  assign cdb_value    = value_q;
  assign cdb_pc       = pc_q;
  assign overflow_err = ovf_q;

  always_comb begin
    a_empty = (a_cnt_q == '0);
    l_empty = (l_cnt_q == '0);
    a_cand  = !a_empty || alu_valid;
    l_cand  = !l_empty || lsb_valid;
    a_item  = a_empty ? {alu_entry, alu_value, alu_pc} : a_mem_q[a_rp_q];
    l_item  = l_empty ? {lsb_entry, lsb_value} : l_mem_q[l_rp_q];
    gnt_a   = a_cand && (!l_cand || last_q);
    gnt_l   = l_cand && !gnt_a;
    pop_a   = gnt_a && !a_empty;
    pop_l   = gnt_l && !l_empty;
    // An input is bypassed only when it wins straight from an empty FIFO.
    push_a    = alu_valid && !(gnt_a && a_empty);
    push_l    = lsb_valid && !(gnt_l && l_empty);
    ok_push_a = push_a && !alu_full;
    ok_push_l = push_l && !lsb_full;
  end

  always_comb begin
    a_mem_d = a_mem_q;
    l_mem_d = l_mem_q;
    a_wp_d  = a_wp_q;
    a_rp_d  = a_rp_q;
    a_cnt_d = a_cnt_q;
    l_wp_d  = l_wp_q;
    l_rp_d  = l_rp_q;
    l_cnt_d = l_cnt_q;
    last_d  = last_q;
    valid_d = valid_q;
    src_d   = src_q;
    entry_d = entry_q;
    value_d = value_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    if (rdy_in) begin
      if (roll_back) begin
        a_wp_d  = '0;
        a_rp_d  = '0;
        a_cnt_d = '0;
        l_wp_d  = '0;
        l_rp_d  = '0;
        l_cnt_d = '0;
        last_d  = 1'b1;
        valid_d = 1'b0;
        src_d   = 1'b0;
        entry_d = '0;
        value_d = '0;
        pc_d    = '0;
      end else begin
        valid_d = gnt_a || gnt_l;
        if (gnt_a) begin
          last_d  = 1'b0;
          src_d   = 1'b0;
          entry_d = a_item[AW-1 -: ENTRY_W];
          value_d = a_item[63:32];
          pc_d    = a_item[31:0];
        end else if (gnt_l) begin
          last_d  = 1'b1;
          src_d   = 1'b1;
          entry_d = l_item[LW-1 -: ENTRY_W];
          value_d = l_item[31:0];
          pc_d    = '0;
        end
        if (pop_a) a_rp_d = a_rp_q + PTR_W'(1);
        if (pop_l) l_rp_d = l_rp_q + PTR_W'(1);
        if (ok_push_a) begin
          a_mem_d[a_wp_q] = {alu_entry, alu_value, alu_pc};
          a_wp_d          = a_wp_q + PTR_W'(1);
        end
        if (ok_push_l) begin
          l_mem_d[l_wp_q] = {lsb_entry, lsb_value};
          l_wp_d          = l_wp_q + PTR_W'(1);
        end
        a_cnt_d = a_cnt_q + (PTR_W + 1)'(ok_push_a) - (PTR_W + 1)'(pop_a);
        l_cnt_d = l_cnt_q + (PTR_W + 1)'(ok_push_l) - (PTR_W + 1)'(pop_l);
        ovf_d   = ovf_q | (push_a && alu_full) | (push_l && lsb_full);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_wp_q  <= '0;
      a_rp_q  <= '0;
      a_cnt_q <= '0;
      l_wp_q  <= '0;
      l_rp_q  <= '0;
      l_cnt_q <= '0;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      entry_q <= '0;
      value_q <= '0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      a_wp_q  <= a_wp_d;
      a_rp_q  <= a_rp_d;
      a_cnt_q <= a_cnt_d;
      l_wp_q  <= l_wp_d;
      l_rp_q  <= l_rp_d;
      l_cnt_q <= l_cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      entry_q <= entry_d;
      value_q <= value_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk_in) begin
    a_mem_q <= a_mem_d;
    l_mem_q <= l_mem_d;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int unsigned EW = 6;
  localparam int unsigned D  = 4;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          rst_in, rdy_in, roll_back;
  logic          alu_valid, lsb_valid, alu_full, lsb_full;
  logic [EW-1:0] alu_entry, lsb_entry, cdb_entry;
  logic [31:0]   alu_value, alu_pc, lsb_value, cdb_value, cdb_pc;
  logic          cdb_valid, cdb_src, overflow_err;

  always #5 clk = ~clk;

  cdb_arbiter #(.ENTRY_W(EW), .DEPTH(D), .PTR_W(PW)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .alu_valid(alu_valid), .alu_entry(alu_entry), .alu_value(alu_value), .alu_pc(alu_pc),
    .alu_full(alu_full), .lsb_valid(lsb_valid), .lsb_entry(lsb_entry),
    .lsb_value(lsb_value), .lsb_full(lsb_full), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
    .cdb_entry(cdb_entry), .cdb_value(cdb_value), .cdb_pc(cdb_pc),
    .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [EW-1:0] e;
    logic [31:0]   v;
    logic [31:0]   pc;
  } item_t;

  item_t         qa[$];
  item_t         ql[$];
  logic          m_valid, m_src, m_last, m_ovf;
  logic [EW-1:0] m_entry;
  logic [31:0]   m_value, m_pc;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    ql.delete();
    m_valid = 1'b0; m_src = 1'b0; m_entry = '0; m_value = '0; m_pc = '0;
    m_last  = 1'b1;
  endtask

  // Called at the active edge with the inputs that edge samples.
  task automatic model_step();
    bit    ca, cl, fa, fl, any, g, byp_a, byp_l;
    item_t ia, il;
    if (rst_in) begin
      model_clear();
      m_ovf = 1'b0;
    end else if (rdy_in) begin
      if (roll_back) begin
        model_clear();
      end else begin
        fa = (qa.size() == D);
        fl = (ql.size() == D);
        ca = (qa.size() > 0) || alu_valid;
        cl = (ql.size() > 0) || lsb_valid;
        ia = (qa.size() > 0) ? qa[0] : item_t'{e: alu_entry, v: alu_value, pc: alu_pc};
        il = (ql.size() > 0) ? ql[0] : item_t'{e: lsb_entry, v: lsb_value, pc: 32'h0};
        any = ca || cl;
        if (ca && cl) g = ~m_last;
        else          g = cl;
        byp_a = 1'b0;
        byp_l = 1'b0;
        m_valid = any;
        if (any) begin
          m_last = g;
          m_src  = g;
          if (!g) begin
            m_entry = ia.e; m_value = ia.v; m_pc = ia.pc;
            if (qa.size() > 0) void'(qa.pop_front()); else byp_a = 1'b1;
          end else begin
            m_entry = il.e; m_value = il.v; m_pc = 32'h0;
            if (ql.size() > 0) void'(ql.pop_front()); else byp_l = 1'b1;
          end
        end
        if (alu_valid && !byp_a) begin
          if (fa) m_ovf = 1'b1;
          else qa.push_back(item_t'{e: alu_entry, v: alu_value, pc: alu_pc});
        end
        if (lsb_valid && !byp_l) begin
          if (fl) m_ovf = 1'b1;
          else ql.push_back(item_t'{e: lsb_entry, v: lsb_value, pc: 32'h0});
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit rdy, input bit rb,
                      input bit av, input logic [EW-1:0] ae, input logic [31:0] avl,
                      input logic [31:0] apc,
                      input bit lv, input logic [EW-1:0] le, input logic [31:0] lvl);
    rst_in = rst; rdy_in = rdy; roll_back = rb;
    alu_valid = av; alu_entry = ae; alu_value = avl; alu_pc = apc;
    lsb_valid = lv; lsb_entry = le; lsb_value = lvl;
    @(posedge clk);
    model_step();
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("cdb_entry", 64'(cdb_entry), 64'(m_entry));
    chk("cdb_value", 64'(cdb_value), 64'(m_value));
    chk("cdb_pc", 64'(cdb_pc), 64'(m_pc));
    chk("alu_full", 64'(alu_full), 64'(qa.size() == D));
    chk("lsb_full", 64'(lsb_full), 64'(ql.size() == D));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, '0, '0, '0, 0, '0, '0);
    step(1, 1, 0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic both(input int n, input logic [EW-1:0] base);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 1, base + EW'(i), 32'hA000 + i, 32'h400 + 4 * i,
           1, base + EW'(16 + i), 32'hB000 + i);
  endtask

  initial begin
    m_ovf = 1'b0;
    model_clear();
    do_reset();
    chk("reset_valid", 64'(cdb_valid), 64'h0);
    chk("reset_ovf", 64'(overflow_err), 64'h0);

    // Single result
    step(0, 1, 0, 1, 6'd5, 32'h11, 32'h80, 0, '0, '0);
    chk("t1_entry", 64'(cdb_entry), 64'd5);
    chk("t1_value", 64'(cdb_value), 64'h11);
    idle(1);
    chk("t1_drop", 64'(cdb_valid), 64'h0);

    // Tie after reset: ALU first, LSB from its FIFO next
    do_reset();
    step(0, 1, 0, 1, 6'd1, 32'h21, 32'h84, 1, 6'd2, 32'h22);
    chk("t2_first", {63'h0, cdb_src}, 64'h0);
    chk("t2_first_tag", 64'(cdb_entry), 64'd1);
    idle(1);
    chk("t2_second", {63'h0, cdb_src}, 64'h1);
    chk("t2_second_tag", 64'(cdb_entry), 64'd2);
    idle(2);

    // Saturation, long enough to overflow the LSB FIFO
    both(6, 6'd0);
    both(10, 6'd32);
    chk("t3_ovf", 64'(overflow_err), 64'h1);
    idle(12);

    // Flush keeps overflow_err and discards the flush-cycle input
    do_reset();
    both(6, 6'd8);
    step(0, 1, 1, 1, 6'd60, 32'hDEAD, 32'h0, 0, '0, '0);
    chk("t4_valid", 64'(cdb_valid), 64'h0);
    chk("t4_full", 64'(alu_full), 64'h0);
    idle(4);
    both(10, 6'd0);
    step(0, 1, 1, 0, '0, '0, '0, 0, '0, '0);
    chk("t4_ovf_sticky", 64'(overflow_err), 64'h1);

    // Pause with entries queued
    do_reset();
    both(3, 6'd40);
    for (int i = 0; i < 3; i++)
      step(0, 0, i == 1, 1, 6'd63, 32'hFFFF, 32'h0, 1, 6'd62, 32'hEEEE);
    idle(6);

    // Pointer wrap: one ALU result per cycle, each broadcast next cycle
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, EW'(i + 20), 32'h3000 + i, 32'h500 + i, 0, '0, '0);
      chk("t6_tag", 64'(cdb_entry), 64'(i + 20));
    end
    idle(1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit r, p, f, av, lv;
      r  = ($urandom_range(99) < 1);
      p  = ($urandom_range(99) < 88);
      f  = ($urandom_range(99) < 3);
      av = ($urandom_range(9) < 6) && (!alu_full || $urandom_range(9) == 0);
      lv = ($urandom_range(9) < 6) && (!lsb_full || $urandom_range(9) == 0);
      step(r, p, f, av, EW'($urandom), $urandom, $urandom, lv, EW'($urandom), $urandom);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
